// File: rtl/read_pointer.sv
// Read-domain pointer and flag logic for the dual-clock FIFO.
// Synchronizes the Gray write pointer, keeps the binary/Gray read counters
// and produces registered empty, almost-empty, level and read-valid outputs.
module read_pointer #(
    parameter int ADDR_SIZE   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE:0]   wr_ptr_i,
    input  logic                 inc_i,
    output logic [ADDR_SIZE:0]   ptr_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic [ADDR_SIZE:0]   level_o,
    output logic                 rd_valid_o
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wr_sync;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] bin_cnt;
    logic [PW-1:0] gray_cnt;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] level_next;
    logic          acc;

    // Synchronizer chain bringing the write pointer into this clock domain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_sync = sync_q[SYNC_STAGES-1];

    // Gray-to-binary of the synchronized write pointer: each bit is the XOR of itself and all bits above
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin[i] = ^(wr_sync >> i);
        end
    end

    // A read is only honoured while the FIFO is seen as non-empty
    assign acc        = inc_i & ~empty_o;
    assign bin_next   = bin_cnt + {{ADDR_SIZE{1'b0}}, acc};
    assign gray_next  = bin_next ^ (bin_next >> 1);
    assign level_next = wr_bin - bin_next;

    // Read counters, flags and occupancy all update together from the pre-edge synchronized pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_cnt        <= '0;
            gray_cnt       <= '0;
            empty_o        <= 1'b1;
            almost_empty_o <= 1'b1;
            level_o        <= '0;
            rd_valid_o     <= 1'b0;
        end else begin
            bin_cnt        <= bin_next;
            gray_cnt       <= gray_next;
            empty_o        <= (gray_next == wr_sync);
            almost_empty_o <= (level_next <= AE_LIMIT);
            level_o        <= level_next;
            rd_valid_o     <= acc;
        end
    end

    assign ptr_o  = gray_cnt;
    assign addr_o = bin_cnt[ADDR_SIZE-1:0];

endmodule
